// File: rtl/itu656_pkg.sv
// rtl/itu656_pkg.sv - shared constants, state encodings and XY check for the BT.656 decoder
package itu656_pkg;

    localparam logic [7:0] TRS_FF = 8'hFF;
    localparam logic [7:0] TRS_00 = 8'h00;

    localparam int DEF_MAX_PAIRS = 360;
    localparam int DEF_MAX_LINES = 312;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_P1,
        ST_P2,
        ST_XY
    } trs_state_t;

    typedef enum logic [1:0] {
        PH_CB,
        PH_Y0,
        PH_CR,
        PH_Y1
    } phase_t;

    // XY = {1,F,V,H,P3,P2,P1,P0}; protection bits are parities of F/V/H.
    function automatic logic xy_ok(input logic [7:0] b);
        logic f, v, h;
        f = b[6];
        v = b[5];
        h = b[4];
        return b[7] && (b[3] == (v ^ h)) && (b[2] == (f ^ h)) &&
               (b[1] == (f ^ v)) && (b[0] == (f ^ v ^ h));
    endfunction

endpackage

// File: rtl/itu656_if.sv
// rtl/itu656_if.sv - decoded pixel-pair and timing outputs of the BT.656 decoder
// master: driven by itu656_decoder; slave: consumed by the line buffer
interface itu656_if;
    logic       pair_valid;
    logic [7:0] pair_cb;
    logic [7:0] pair_y0;
    logic [7:0] pair_cr;
    logic [7:0] pair_y1;
    logic [8:0] pair_x;
    logic [8:0] line;
    logic       field;
    logic       vblank;
    logic       sol;
    logic       sof;
    logic       xy_err;
    logic       ovf;

    modport master (
        output pair_valid, pair_cb, pair_y0, pair_cr, pair_y1, pair_x, line,
        output field, vblank, sol, sof, xy_err, ovf
    );

    modport slave (
        input pair_valid, pair_cb, pair_y0, pair_cr, pair_y1, pair_x, line,
        input field, vblank, sol, sof, xy_err, ovf
    );
endinterface

// File: rtl/itu656_trs_detect.sv
// rtl/itu656_trs_detect.sv - FF 00 00 XY preamble tracker and XY protection check
// Ports: clk, rst_n; d (registered stream byte); code_valid/code_err (XY byte judged
// this cycle); code_f/v/h (XY flags); preamble_hit (byte is FF); hunt (no preamble in progress)
module itu656_trs_detect
    import itu656_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] d,
    output logic       code_valid,
    output logic       code_err,
    output logic       code_f,
    output logic       code_v,
    output logic       code_h,
    output logic       preamble_hit,
    output logic       hunt
);

    trs_state_t state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        code_valid = 1'b0;
        code_err   = 1'b0;
        case (state_q)
            ST_HUNT: if (d == TRS_FF) state_d = ST_P1;
            ST_P1: begin
                if (d == TRS_00)      state_d = ST_P2;
                else if (d != TRS_FF) state_d = ST_HUNT;
            end
            ST_P2: begin
                if (d == TRS_00)      state_d = ST_XY;
                else if (d == TRS_FF) state_d = ST_P1;
                else                  state_d = ST_HUNT;
            end
            ST_XY: begin
                state_d    = ST_HUNT;
                code_valid = xy_ok(d);
                code_err   = !xy_ok(d);
            end
            default: state_d = ST_HUNT;
        endcase
    end

    assign code_f       = d[6];
    assign code_v       = d[5];
    assign code_h       = d[4];
    assign preamble_hit = (d == TRS_FF);
    assign hunt         = (state_q == ST_HUNT);

endmodule

// File: rtl/itu656_decoder.sv
// rtl/itu656_decoder.sv - BT.656 byte stream to 4:2:2 pixel pairs with line/field timing
// Ports: clk, rst_n (async active-low), td_data (BT.656 bytes), bus (itu656_if.master:
// pair_valid/cb/y0/cr/y1/pair_x/line, field, vblank, sol, sof, xy_err, ovf)
module itu656_decoder
    import itu656_pkg::*;
#(
    parameter int MAX_PAIRS = DEF_MAX_PAIRS,
    parameter int MAX_LINES = DEF_MAX_LINES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  td_data,
    itu656_if.master    bus
);

    logic [7:0] d_q;
    logic       code_valid, code_err, code_f, code_v, code_h;
    logic       preamble_hit, hunt;
    logic       active;
    phase_t     phase;
    logic [8:0] pair_cnt;
    logic [7:0] cb_q, y0_q, cr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) d_q <= 8'h00;
        else        d_q <= td_data;
    end

    itu656_trs_detect u_trs (
        .clk          (clk),
        .rst_n        (rst_n),
        .d            (d_q),
        .code_valid   (code_valid),
        .code_err     (code_err),
        .code_f       (code_f),
        .code_v       (code_v),
        .code_h       (code_h),
        .preamble_hit (preamble_hit),
        .hunt         (hunt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active         <= 1'b0;
            phase          <= PH_CB;
            pair_cnt       <= 9'd0;
            cb_q           <= 8'h00;
            y0_q           <= 8'h00;
            cr_q           <= 8'h00;
            bus.pair_valid <= 1'b0;
            bus.pair_cb    <= 8'h00;
            bus.pair_y0    <= 8'h00;
            bus.pair_cr    <= 8'h00;
            bus.pair_y1    <= 8'h00;
            bus.pair_x     <= 9'd0;
            bus.line       <= 9'd0;
            bus.field      <= 1'b0;
            bus.vblank     <= 1'b1;
            bus.sol        <= 1'b0;
            bus.sof        <= 1'b0;
            bus.xy_err     <= 1'b0;
            bus.ovf        <= 1'b0;
        end else begin
            bus.pair_valid <= 1'b0;
            bus.sol        <= 1'b0;
            bus.sof        <= 1'b0;
            bus.xy_err     <= 1'b0;
            if (code_err) begin
                bus.xy_err <= 1'b1;
            end else if (code_valid) begin
                bus.field  <= code_f;
                bus.vblank <= code_v;
                if (code_h || code_v) begin
                    active <= 1'b0;
                end else begin
                    active   <= 1'b1;
                    phase    <= PH_CB;
                    pair_cnt <= 9'd0;
                    bus.sol  <= 1'b1;
                    bus.ovf  <= 1'b0;
                    // bus.vblank still holds the previous code's V here
                    if (bus.vblank) begin
                        bus.sof  <= 1'b1;
                        bus.line <= 9'd0;
                    end else if (bus.line != 9'(MAX_LINES - 1)) begin
                        bus.line <= bus.line + 9'd1;
                    end
                end
            end else if (active && hunt) begin
                // Bytes seen while a preamble is being matched are not video data;
                // an FF here starts a TRS and throws away any partial pair.
                if (preamble_hit) begin
                    phase <= PH_CB;
                end else begin
                    case (phase)
                        PH_CB: begin cb_q <= d_q; phase <= PH_Y0; end
                        PH_Y0: begin y0_q <= d_q; phase <= PH_CR; end
                        PH_CR: begin cr_q <= d_q; phase <= PH_Y1; end
                        PH_Y1: begin
                            phase <= PH_CB;
                            if (pair_cnt < 9'(MAX_PAIRS)) begin
                                bus.pair_valid <= 1'b1;
                                bus.pair_cb    <= cb_q;
                                bus.pair_y0    <= y0_q;
                                bus.pair_cr    <= cr_q;
                                bus.pair_y1    <= d_q;
                                bus.pair_x     <= pair_cnt;
                                pair_cnt       <= pair_cnt + 9'd1;
                            end else begin
                                bus.ovf <= 1'b1;
                            end
                        end
                        default: phase <= PH_CB;
                    endcase
                end
            end
        end
    end

endmodule
